// File: rtl/pmodad1_reader.sv
// Acquisition front end for the dual AD7476A PmodAD1: drives SCLK/CS_N, shifts both
// data lines in parallel and presents registered 12-bit codes padded to 16 bits.
module pmodad1_reader #(
    parameter int CLK_DIV      = 50,
    parameter int QUIET_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sdata0,
    input  logic        sdata1,
    output logic        sclk,
    output logic        cs_n,
    output logic [15:0] data_ch1,
    output logic [15:0] data_ch2,
    output logic        valid,
    output logic        busy
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_QUIET = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [DW-1:0]   div_cnt_r;
    logic [QW-1:0]   quiet_cnt_r;
    logic [3:0]      bit_cnt_r;
    logic [15:0]     sh0_r;
    logic [15:0]     sh1_r;
    logic [15:0]     data_ch1_r;
    logic [15:0]     data_ch2_r;
    logic            cs_n_r;
    logic            sclk_r;
    logic            busy_r;
    logic            valid_r;
    logic            div_last_s;
    logic            quiet_last_s;
    logic            bit_last_s;
    logic            frame_done_s;

    assign div_last_s   = (div_cnt_r == DW'(CLK_DIV - 1));
    assign quiet_last_s = (quiet_cnt_r == QW'(QUIET_CYCLES - 1));
    assign bit_last_s   = (bit_cnt_r == 4'd15);
    assign frame_done_s = (state_r == ST_HIGH) && div_last_s && bit_last_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; each SCLK phase lasts CLK_DIV cycles
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_SETUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (div_last_s) begin
                    state_next_s = ST_LOW;
                end else begin
                    state_next_s = ST_SETUP;
                end
            end
            ST_LOW: begin
                if (div_last_s) begin
                    state_next_s = ST_HIGH;
                end else begin
                    state_next_s = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (div_last_s && bit_last_s) begin
                    state_next_s = ST_QUIET;
                end else if (div_last_s) begin
                    state_next_s = ST_LOW;
                end else begin
                    state_next_s = ST_HIGH;
                end
            end
            ST_QUIET: begin
                if (quiet_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_QUIET;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Phase, quiet and bit counters
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r   <= '0;
            quiet_cnt_r <= '0;
            bit_cnt_r   <= 4'd0;
        end else begin
            if (state_next_s != state_r) begin
                div_cnt_r <= '0;
            end else if (state_r == ST_SETUP || state_r == ST_LOW || state_r == ST_HIGH) begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end else begin
                div_cnt_r <= '0;
            end

            if (state_r == ST_QUIET && state_next_s == ST_QUIET) begin
                quiet_cnt_r <= quiet_cnt_r + QW'(1);
            end else begin
                quiet_cnt_r <= '0;
            end

            if (state_r == ST_IDLE || state_r == ST_SETUP) begin
                bit_cnt_r <= 4'd0;
            end else if (state_r == ST_HIGH && div_last_s && !bit_last_s) begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // Sample both lines at the end of each SCLK low phase, just before the rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sh0_r <= 16'h0000;
            sh1_r <= 16'h0000;
        end else if (state_r == ST_LOW && div_last_s) begin
            sh0_r <= {sh0_r[14:0], sdata0};
            sh1_r <= {sh1_r[14:0], sdata1};
        end else begin
            sh0_r <= sh0_r;
            sh1_r <= sh1_r;
        end
    end

    // Registered outputs decoded from the upcoming state; leading four bits are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n_r     <= 1'b1;
            sclk_r     <= 1'b1;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            data_ch1_r <= 16'h0000;
            data_ch2_r <= 16'h0000;
        end else begin
            cs_n_r  <= !(state_next_s == ST_SETUP || state_next_s == ST_LOW ||
                         state_next_s == ST_HIGH);
            sclk_r  <= (state_next_s != ST_LOW);
            busy_r  <= (state_next_s != ST_IDLE);
            valid_r <= frame_done_s;
            if (frame_done_s) begin
                data_ch1_r <= {4'b0000, sh0_r[11:0]};
                data_ch2_r <= {4'b0000, sh1_r[11:0]};
            end else begin
                data_ch1_r <= data_ch1_r;
                data_ch2_r <= data_ch2_r;
            end
        end
    end

    assign cs_n     = cs_n_r;
    assign sclk     = sclk_r;
    assign busy     = busy_r;
    assign valid    = valid_r;
    assign data_ch1 = data_ch1_r;
    assign data_ch2 = data_ch2_r;

endmodule

// File: tb/tb_pmodad1_reader.sv
// Bench for pmodad1_reader: behavioural dual-ADC model serialising queued words on
// SCLK falling edges, with frame-level expectations derived from word and timing rules.
module tb_pmodad1_reader;

    localparam int CLK_DIV    = 2;
    localparam int QUIET      = 4;
    localparam int FRAME_BUSY = CLK_DIV * 33 + QUIET;
    localparam int BOUND      = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sdata0 = 1'b0;
    logic        sdata1 = 1'b0;
    logic        sclk;
    logic        cs_n;
    logic [15:0] data_ch1;
    logic [15:0] data_ch2;
    logic        valid;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] w0_arr [0:63];
    logic [15:0] w1_arr [0:63];

    int          cyc = 0;
    int          busy_cnt = 0;
    int          valid_cnt = 0;
    int          cs_fall_cnt = 0;
    int          sclk_fall_cnt = 0;
    int          valid_cyc = 0;
    int          cs_fall_cyc = 0;
    int          model_frames = 0;
    int          bitk = 0;
    logic [15:0] last_d1 = 16'h0000;
    logic [15:0] last_d2 = 16'h0000;
    logic [15:0] cur0 = 16'h0000;
    logic [15:0] cur1 = 16'h0000;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b1;

    pmodad1_reader #(.CLK_DIV(CLK_DIV), .QUIET_CYCLES(QUIET)) dut (
        .clk(clk), .rst(rst), .start(start), .sdata0(sdata0), .sdata1(sdata1),
        .sclk(sclk), .cs_n(cs_n), .data_ch1(data_ch1), .data_ch2(data_ch2),
        .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor plus ADC model: a CS_N fall loads the next word pair, each SCLK fall
    // presents the next bit MSB first
    always @(negedge clk) begin
        cyc++;
        if (busy === 1'b1) busy_cnt++;
        if (valid === 1'b1) begin
            valid_cnt++;
            last_d1   = data_ch1;
            last_d2   = data_ch2;
            valid_cyc = cyc;
        end
        if (prev_cs === 1'b1 && cs_n === 1'b0) begin
            cs_fall_cnt++;
            cs_fall_cyc = cyc;
            cur0 = w0_arr[model_frames % 64];
            cur1 = w1_arr[model_frames % 64];
            model_frames++;
            bitk = 0;
        end
        if (prev_sclk === 1'b1 && sclk === 1'b0 && cs_n === 1'b0) begin
            sclk_fall_cnt++;
            if (bitk < 16) begin
                sdata0 = cur0[15 - bitk];
                sdata1 = cur1[15 - bitk];
                bitk++;
            end
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < BOUND) begin
            tick();
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s idle timeout: busy=%b required 0", name, busy);
        end
    endtask

    task automatic wait_valid(input int target, input string name);
        int n = 0;
        while (valid_cnt < target && n < BOUND) begin
            tick();
            n++;
        end
        n_checks++;
        if (valid_cnt < target) begin
            n_errors++;
            $display("FAIL %s valid timeout: count=%0d required %0d", name, valid_cnt, target);
        end
    endtask

    task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input string name);
        w0_arr[model_frames % 64] = a;
        w1_arr[model_frames % 64] = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(name);
    endtask

    task automatic check_frame(input logic [15:0] a, input logic [15:0] b, input string name);
        int vb = valid_cnt;
        int sb = sclk_fall_cnt;
        int bb = busy_cnt;
        int cb = cs_fall_cnt;
        logic [15:0] e1 = a & 16'h0FFF;
        logic [15:0] e2 = b & 16'h0FFF;
        run_frame(a, b, name);
        n_checks++;
        if (sclk_fall_cnt - sb != 16) begin
            n_errors++;
            $display("FAIL %s sclk_falls: got %0d required 16", name, sclk_fall_cnt - sb);
        end
        n_checks++;
        if (valid_cnt - vb != 1) begin
            n_errors++;
            $display("FAIL %s valid_pulses: got %0d required 1", name, valid_cnt - vb);
        end
        n_checks++;
        if (cs_fall_cnt - cb != 1) begin
            n_errors++;
            $display("FAIL %s cs_falls: got %0d required 1", name, cs_fall_cnt - cb);
        end
        n_checks++;
        if (busy_cnt - bb != FRAME_BUSY) begin
            n_errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt - bb, FRAME_BUSY);
        end
        n_checks++;
        if (last_d1 !== e1 || last_d2 !== e2) begin
            n_errors++;
            $display("FAIL %s data_at_valid: got %h/%h required %h/%h", name, last_d1, last_d2, e1, e2);
        end
        repeat (7) tick();
        n_checks++;
        if (data_ch1 !== e1 || data_ch2 !== e2) begin
            n_errors++;
            $display("FAIL %s data_hold: got %h/%h required %h/%h", name, data_ch1, data_ch2, e1, e2);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (cs_n !== 1'b1 || sclk !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 ||
            data_ch1 !== 16'h0000 || data_ch2 !== 16'h0000) begin
            n_errors++;
            $display("FAIL %s: cs_n=%b sclk=%b valid=%b busy=%b d1=%h d2=%h required 1 1 0 0 0000 0000",
                     name, cs_n, sclk, valid, busy, data_ch1, data_ch2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        tick();
        check_reset_outputs("reset_first_cycle");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset_released");
    endtask

    task automatic test_single_frame();
        check_frame(16'h0ABC, 16'h0123, "single_frame");
    endtask

    task automatic test_masking();
        check_frame(16'hFABC, 16'hF123, "leading_mask");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            check_frame(16'($urandom), 16'($urandom), $sformatf("random_%0d", i));
        end
    endtask

    task automatic test_ignored_start();
        int vb = valid_cnt;
        int cb = cs_fall_cnt;
        int n = 0;
        w0_arr[model_frames % 64] = 16'h0456;
        w1_arr[model_frames % 64] = 16'h0789;
        start = 1'b1;
        while (valid_cnt == vb && n < BOUND) begin
            tick();
            n++;
        end
        start = 1'b0;
        wait_idle("ignored_start");
        repeat (10) tick();
        n_checks++;
        if (cs_fall_cnt - cb != 1 || valid_cnt - vb != 1) begin
            n_errors++;
            $display("FAIL ignored_start frames: cs_falls=%0d valids=%0d required 1 1",
                     cs_fall_cnt - cb, valid_cnt - vb);
        end
        n_checks++;
        if (data_ch1 !== 16'h0456 || data_ch2 !== 16'h0789) begin
            n_errors++;
            $display("FAIL ignored_start data: got %h/%h required 0456/0789", data_ch1, data_ch2);
        end
    endtask

    task automatic test_back_to_back();
        int vb = valid_cnt;
        int cb = cs_fall_cnt;
        int n = 0;
        int v1;
        int c2;
        logic [15:0] d_first;
        w0_arr[model_frames % 64]       = 16'h0001;
        w1_arr[model_frames % 64]       = 16'h0001;
        w0_arr[(model_frames + 1) % 64] = 16'h0FFF;
        w1_arr[(model_frames + 1) % 64] = 16'h0FFF;
        start = 1'b1;
        wait_valid(vb + 1, "b2b_first");
        v1 = valid_cyc;
        d_first = last_d1;
        while (cs_fall_cnt < cb + 2 && n < BOUND) begin
            tick();
            n++;
        end
        c2 = cs_fall_cyc;
        n_checks++;
        if (cs_fall_cnt != cb + 2 || c2 - v1 != QUIET + 1) begin
            n_errors++;
            $display("FAIL b2b_gap: cs_falls=%0d gap=%0d required %0d %0d",
                     cs_fall_cnt - cb, c2 - v1, 2, QUIET + 1);
        end
        wait_valid(vb + 2, "b2b_second");
        start = 1'b0;
        wait_idle("b2b");
        n_checks++;
        if (d_first !== 16'h0001 || last_d1 !== 16'h0FFF || last_d2 !== 16'h0FFF) begin
            n_errors++;
            $display("FAIL b2b_data: got %h then %h/%h required 0001 then 0fff/0fff",
                     d_first, last_d1, last_d2);
        end
    endtask

    task automatic test_mid_frame_reset();
        int sb = sclk_fall_cnt;
        int vb;
        int n = 0;
        w0_arr[model_frames % 64] = 16'h0AAA;
        w1_arr[model_frames % 64] = 16'h0AAA;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (sclk_fall_cnt < sb + 9 && n < BOUND) begin
            tick();
            n++;
        end
        vb = valid_cnt;
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_reset_first_cycle");
        tick();
        tick();
        rst = 1'b0;
        repeat (QUIET + CLK_DIV * 40) tick();
        n_checks++;
        if (valid_cnt != vb || cs_n !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_abort: valids=%0d cs_n=%b busy=%b required 0 1 0",
                     valid_cnt - vb, cs_n, busy);
        end
        check_frame(16'h0555, 16'h0555, "after_mid_reset");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            w0_arr[i] = 16'h0000;
            w1_arr[i] = 16'h0000;
        end
        test_reset();
        test_single_frame();
        test_masking();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_mid_frame_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pmodad1_reader.md
Name: pmodad1_reader

Overview:
- SPI-style acquisition front end for the PmodAD1, a dual AD7476A 12-bit ADC in the HPA output power sensor.
- Drives the shared SCLK and CS_N and shifts in both ADC data lines in parallel.
- Presents registered 16-bit channel words plus a one-cycle valid strobe. These words are the data_ch1/data_ch2 values the display block consumes.

Parameters:
- CLK_DIV, 50, system clocks per SCLK half-period; legal range ≥2. Default gives 1 MHz SCLK at 100 MHz.
- QUIET_CYCLES, 50, system clocks CS_N stays high after a frame before the next start is accepted; legal range ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request one conversion; sampled only in IDLE
- sdata0  in  1  ADC channel 1 serial data (PmodAD1 D0)
- sdata1  in  1  ADC channel 2 serial data (PmodAD1 D1)
- sclk  out  1  serial clock to both ADCs, idles high
- cs_n  out  1  chip select to both ADCs, active low
- data_ch1  out  16  last completed channel 1 sample, {4'b0000, 12-bit code}
- data_ch2  out  16  last completed channel 2 sample, {4'b0000, 12-bit code}
- valid  out  1  one-cycle pulse when data_ch1/data_ch2 update
- busy  out  1  high from the cycle after start is accepted until return to IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values, applied on any clk edge with rst=1, including mid-frame:
  - state=IDLE, cs_n=1, sclk=1, valid=0, busy=0
  - data_ch1=0, data_ch2=0, shift registers and counters cleared
  - A frame aborted by reset produces no valid pulse.
- States: IDLE, SETUP, LOW, HIGH, QUIET.
- IDLE:
  - cs_n=1, sclk=1, busy=0.
  - start=1 at edge t → SETUP, so cs_n=0 and busy=1 from cycle t+1.
  - start in any other state is ignored; it is not queued.
- SETUP:
  - cs_n=0, sclk=1 for CLK_DIV cycles, then → LOW with bit counter=0.
- LOW:
  - sclk=0 for CLK_DIV cycles.
  - On the last cycle of LOW, sdata0 and sdata1 are shifted MSB-first into 16-bit shift registers: sh = {sh[14:0], sdata}.
  - Then → HIGH.
- HIGH:
  - sclk=1 for CLK_DIV cycles.
  - If bit counter=15 → QUIET; otherwise increment the counter and → LOW.
  - Exactly 16 falling SCLK edges per frame.
- On entry to QUIET (one cycle):
  - cs_n=1.
  - data_ch1 ← {4'b0000, sh0[11:0]} and data_ch2 ← {4'b0000, sh1[11:0]}. The four leading bits are discarded regardless of their value.
  - valid=1 for exactly this cycle.
- QUIET:
  - cs_n=1, sclk=1 for QUIET_CYCLES cycles, then → IDLE with busy=0.
  - start asserted in the IDLE cycle that follows is accepted (back-to-back).
- Frame timing: busy high for CLK_DIV×33 + QUIET_CYCLES cycles. cs_n low for CLK_DIV×33 cycles.
- data_ch1/data_ch2 hold their value between valid pulses.
- Counters: half-period counter width = clog2(CLK_DIV). Bit counter is 4 bits, with no wrap beyond 15.
- sclk and cs_n are driven from registers, with no combinational path from inputs.
- sdata0/sdata1 are sampled directly. The ADC launches data on the SCLK falling edge, so each bit has ≥CLK_DIV−1 cycles of setup.

Test Plan:
- Reset: hold rst 3 cycles, with and without a frame in progress → cs_n=1, sclk=1, valid=0, busy=0, data_ch1=data_ch2=0x0000 on the cycle after the reset edge.
- Single frame, CLK_DIV=2, QUIET_CYCLES=4: sdata0 model serialises 0x0ABC and sdata1 serialises 0x0123 on SCLK falling edges.
  - Required: exactly 16 sclk low pulses.
  - Required: valid for 1 cycle with data_ch1=0x0ABC, data_ch2=0x0123.
  - Required: busy high for 70 cycles.
- Leading-bit masking: models drive 0xFABC and 0xF123 → data_ch1=0x0ABC, data_ch2=0x0123.
- Ignored start: pulse start every cycle during a frame → one frame only; cs_n falls once; one valid pulse.
- Back-to-back: start held high continuously with words 0x0001 then 0x0FFF.
  - Required: second cs_n fall exactly QUIET_CYCLES+1 cycles after the first valid.
  - Required: outputs 0x0001 then 0x0FFF.
- Mid-frame reset: assert rst during bit 8 → cs_n=1 next cycle, no valid. Following start yields a correct full frame, data 0x0555.
